// File: rtl/accel_stream_loader.sv
// rtl/accel_stream_loader.sv - packs a beat stream into accelerator memory writes, then sequences start/eol/eoc
// Optional watchdog: define ACCEL_LOADER_TIMEOUT_EN to add timeoutCycles and the sticky err flag.
module accel_stream_loader #(
    parameter int logNumPu         = 3,
    parameter int logNumPe         = 3,
    parameter int memDataLen       = 16,
    parameter int logMemNamespaces = 2,
    parameter int logNumMemLanes   = 4,
`ifdef ACCEL_LOADER_TIMEOUT_EN
    parameter int timeoutCycles    = 4096,
`endif
    localparam int numMemLanes      = 1 << logNumMemLanes,
    localparam int logNumPeMemLanes = logNumPu + logNumPe - logNumMemLanes,
    localparam int numPeMemLanes    = 1 << logNumPeMemLanes,
    localparam int memCtrlIn        = logMemNamespaces + (logNumPeMemLanes + 1) * numMemLanes
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [logMemNamespaces-1:0]        in_ns,
    input  logic [memDataLen*numMemLanes-1:0]  in_data,
    input  logic                               in_last,
    output logic [memCtrlIn-1:0]               mem_ctrl_in,
    output logic [memDataLen*numMemLanes-1:0]  mem_data_input,
    output logic                               mem_rd_wrt,
    output logic                               start,
    output logic                               eoc,
    input  logic                               eol,
    output logic                               busy,
    output logic                               done,
    output logic [31:0]                        run_cycles,
    output logic                               err
);

    localparam int sel_w   = logNumPeMemLanes;
    localparam int field_w = logNumPeMemLanes + 1;

    typedef enum logic [2:0] {IDLE, LOAD, GAP, START, RUN, EOC} state_t;

    state_t                      state, state_next;
    logic                        accept;
    logic                        timeout;
    logic [sel_w-1:0]            sel_q, sel_cur, sel_next;
    logic [logMemNamespaces-1:0] prev_ns;
    logic [memCtrlIn-1:0]        ctrl_pack;

    assign in_ready   = (state == IDLE) || (state == LOAD);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign done       = eoc;
    assign mem_rd_wrt = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        eoc        = 1'b0;
        case (state)
            IDLE:    if (accept) state_next = in_last ? GAP : LOAD;
            LOAD:    if (accept && in_last) state_next = GAP;
            GAP:     state_next = START;
            START: begin
                start      = 1'b1;
                state_next = RUN;
            end
            RUN:     if (eol || timeout) state_next = EOC;
            EOC: begin
                eoc        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A namespace switch restarts lane-slot selection for the beat that causes it.
    always_comb begin
        sel_cur   = (in_ns != prev_ns) ? '0 : sel_q;
        sel_next  = (sel_cur == sel_w'(numPeMemLanes - 1)) ? '0 : sel_cur + 1'b1;
        ctrl_pack = '0;
        ctrl_pack[logMemNamespaces-1:0] = in_ns;
        for (int i = 0; i < numMemLanes; i++) begin
            ctrl_pack[logMemNamespaces + i*field_w +: field_w] = {1'b1, sel_cur};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q          <= '0;
            prev_ns        <= '0;
            mem_ctrl_in    <= '0;
            mem_data_input <= '0;
            run_cycles     <= '0;
        end else begin
            mem_ctrl_in    <= '0;
            mem_data_input <= '0;
            if (accept) begin
                prev_ns <= in_ns;
                sel_q   <= in_last ? '0 : sel_next;
                if (in_ns != '0) begin
                    mem_ctrl_in    <= ctrl_pack;
                    mem_data_input <= in_data;
                end
            end
            if (state == START) begin
                run_cycles <= '0;
            end else if (state == RUN && run_cycles != '1) begin
                run_cycles <= run_cycles + 32'd1;
            end
        end
    end

`ifdef ACCEL_LOADER_TIMEOUT_EN
    assign timeout = (run_cycles >= 32'(timeoutCycles - 1));

    // eol on the same cycle as the limit counts as a normal finish.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (state == START) begin
            err <= 1'b0;
        end else if (state == RUN && timeout && !eol) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_accel_stream_loader.sv
// tb/tb_accel_stream_loader.sv - scoreboard bench for accel_stream_loader
module tb_accel_stream_loader;

    localparam int LANES = 16;
    localparam int FW    = 3;
    localparam int CW    = 2 + FW * LANES;
    localparam int DW    = 256;
`ifdef ACCEL_LOADER_TIMEOUT_EN
    localparam int EOL_AT = 30;
`else
    localparam int EOL_AT = 100;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_ns;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [CW-1:0] mem_ctrl_in;
    logic [DW-1:0] mem_data_input;
    logic          mem_rd_wrt;
    logic          start;
    logic          eoc;
    logic          eol;
    logic          busy;
    logic          done;
    logic [31:0]   run_cycles;
    logic          err;

    always #5 clk = ~clk;

`ifdef ACCEL_LOADER_TIMEOUT_EN
    accel_stream_loader #(.timeoutCycles(50)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ns(in_ns), .in_data(in_data), .in_last(in_last),
        .mem_ctrl_in(mem_ctrl_in), .mem_data_input(mem_data_input), .mem_rd_wrt(mem_rd_wrt),
        .start(start), .eoc(eoc), .eol(eol), .busy(busy), .done(done),
        .run_cycles(run_cycles), .err(err)
    );
`else
    accel_stream_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ns(in_ns), .in_data(in_data), .in_last(in_last),
        .mem_ctrl_in(mem_ctrl_in), .mem_data_input(mem_data_input), .mem_rd_wrt(mem_rd_wrt),
        .start(start), .eoc(eoc), .eol(eol), .busy(busy), .done(done),
        .run_cycles(run_cycles), .err(err)
    );
`endif

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_sel;
    logic [1:0] m_prev_ns;

    function automatic logic [CW-1:0] pack(input logic [1:0] ns, input int s);
        logic [CW-1:0] c;
        c      = '0;
        c[1:0] = ns;
        for (int i = 0; i < LANES; i++) c[2 + i*FW +: FW] = {1'b1, 2'(s)};
        return c;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic v, input logic [1:0] ns, input logic [DW-1:0] d, input logic l);
        exp_t e;
        int   cur;
        in_valid = v; in_ns = ns; in_data = d; in_last = l;
        e.ctrl = '0;
        e.data = '0;
        if (v && in_ready) begin
            cur = (ns != m_prev_ns) ? 0 : m_sel;
            if (ns != 2'd0) begin
                e.ctrl = pack(ns, cur);
                e.data = d;
            end
            m_prev_ns = ns;
            m_sel     = l ? 0 : (cur + 1) % 4;
        end
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_run();
        repeat (2) @(negedge clk);
        eol = 1'b1;
        @(negedge clk);
        eol = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || {start, eoc, busy, done, err, mem_rd_wrt} !== 6'b0)
            $display("FAIL reset_ctl: in_ready=%b start/eoc/busy/done/err/rdwrt=%b expected 1 and 000000",
                     in_ready, {start, eoc, busy, done, err, mem_rd_wrt});
        else n_pass++;
        n_checks++;
        if (mem_ctrl_in !== '0 || mem_data_input !== '0 || run_cycles !== 32'd0)
            $display("FAIL reset_data: ctrl=%h data=%h run=%0d expected all 0", mem_ctrl_in, mem_data_input, run_cycles);
        else n_pass++;
    endtask

    task automatic test_load_run();
        logic [1:0]    ns_tab  [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        logic [2:0]    fld_tab [8] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [DW-1:0] lane1 = {LANES{16'h0001}};
        exp_t          e;
        for (int b = 0; b < 8; b++) begin
            drive(1'b1, ns_tab[b], lane1, b == 7);
            e = sb.pop_front();
            n_checks++;
            if (mem_ctrl_in !== e.ctrl || mem_data_input !== e.data)
                $display("FAIL load_bus[%0d]: ctrl=%h data=%h expected ctrl=%h data=%h", b, mem_ctrl_in, mem_data_input, e.ctrl, e.data);
            else n_pass++;
            n_checks++;
            if (mem_ctrl_in[1:0] !== ns_tab[b] || mem_ctrl_in[4:2] !== fld_tab[b] || mem_ctrl_in[49:47] !== fld_tab[b])
                $display("FAIL load_field[%0d]: ns=%b lane0=%b lane15=%b expected ns=%b lanes=%b",
                         b, mem_ctrl_in[1:0], mem_ctrl_in[4:2], mem_ctrl_in[49:47], ns_tab[b], fld_tab[b]);
            else n_pass++;
        end
        n_checks++;
        if (start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL gap: start=%b busy=%b in_ready=%b expected 0 1 0", start, busy, in_ready);
        else n_pass++;
        drive(1'b0, 2'b00, '0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (start !== 1'b1 || mem_ctrl_in !== e.ctrl || mem_data_input !== e.data)
            $display("FAIL start_pulse: start=%b ctrl=%h expected start=1 ctrl=%h", start, mem_ctrl_in, e.ctrl);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (start !== 1'b0 || eoc !== 1'b0 || run_cycles !== 32'd0)
            $display("FAIL run_first: start=%b eoc=%b run=%0d expected 0 0 0", start, eoc, run_cycles);
        else n_pass++;
        repeat (EOL_AT - 1) @(negedge clk);
        n_checks++;
        if (run_cycles !== 32'(EOL_AT - 1) || eoc !== 1'b0)
            $display("FAIL run_count: run=%0d eoc=%b expected %0d 0", run_cycles, eoc, EOL_AT - 1);
        else n_pass++;
        eol = 1'b1;
        @(negedge clk);
        eol = 1'b0;
        n_checks++;
        if (eoc !== 1'b1 || done !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || run_cycles !== 32'(EOL_AT))
            $display("FAIL eoc: eoc=%b done=%b busy=%b err=%b run=%0d expected 1 1 1 0 %0d",
                     eoc, done, busy, err, run_cycles, EOL_AT);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (eoc !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || run_cycles !== 32'(EOL_AT))
            $display("FAIL after_eoc: eoc=%b done=%b busy=%b in_ready=%b run=%0d expected 0 0 0 1 %0d",
                     eoc, done, busy, in_ready, run_cycles, EOL_AT);
        else n_pass++;
    endtask

    task automatic test_toggle();
        logic [2:0] fld_tab [6] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b101};
        exp_t       e;
        eol = 1'b1;
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 2'b11, rnd_data(), j == 5);
            e = sb.pop_front();
            n_checks++;
            if (mem_ctrl_in !== e.ctrl || mem_data_input !== e.data || mem_ctrl_in[4:2] !== fld_tab[j])
                $display("FAIL toggle_beat[%0d]: ctrl=%h data=%h expected ctrl=%h data=%h", j, mem_ctrl_in, mem_data_input, e.ctrl, e.data);
            else n_pass++;
            if (j < 5) begin
                drive(1'b0, 2'b11, rnd_data(), 1'b0);
                e = sb.pop_front();
                n_checks++;
                if (mem_ctrl_in !== e.ctrl || mem_data_input !== e.data || eoc !== 1'b0)
                    $display("FAIL toggle_idle[%0d]: ctrl=%h data=%h eoc=%b expected 0 0 0", j, mem_ctrl_in, mem_data_input, eoc);
                else n_pass++;
            end
        end
        @(negedge clk);
        n_checks++;
        if (start !== 1'b1 || eoc !== 1'b0)
            $display("FAIL eol_ignored_start: start=%b eoc=%b expected 1 0", start, eoc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (eoc !== 1'b0 || busy !== 1'b1)
            $display("FAIL eol_run1: eoc=%b busy=%b expected 0 1", eoc, busy);
        else n_pass++;
        @(negedge clk);
        eol = 1'b0;
        n_checks++;
        if (eoc !== 1'b1 || run_cycles !== 32'd1)
            $display("FAIL eol_short: eoc=%b run=%0d expected 1 1", eoc, run_cycles);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_ns_zero();
        logic [DW-1:0] d2 = rnd_data();
        exp_t          e;
        drive(1'b1, 2'b11, rnd_data(), 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (mem_ctrl_in !== e.ctrl || mem_data_input !== e.data || mem_ctrl_in[4:2] !== 3'b100)
            $display("FAIL nsz_first: ctrl=%h expected %h", mem_ctrl_in, e.ctrl);
        else n_pass++;
        drive(1'b1, 2'b00, rnd_data(), 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (mem_ctrl_in !== '0 || mem_data_input !== '0 || mem_ctrl_in !== e.ctrl)
            $display("FAIL nsz_middle: ctrl=%h data=%h expected 0 0", mem_ctrl_in, mem_data_input);
        else n_pass++;
        drive(1'b1, 2'b11, d2, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (mem_ctrl_in !== e.ctrl || mem_data_input !== d2 || mem_ctrl_in[4:2] !== 3'b100)
            $display("FAIL nsz_third: ctrl=%h data=%h expected ctrl=%h data=%h", mem_ctrl_in, mem_data_input, e.ctrl, d2);
        else n_pass++;
        finish_run();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 2'b01, rnd_data(), 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 2'b01, rnd_data(), 1'b0);
        void'(sb.pop_front());
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || mem_ctrl_in !== '0)
            $display("FAIL reset_load: busy=%b in_ready=%b ctrl=%h expected 0 1 0", busy, in_ready, mem_ctrl_in);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1; m_sel = 0; m_prev_ns = 2'b00;
        drive(1'b1, 2'b10, rnd_data(), 1'b1);
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || start !== 1'b0)
            $display("FAIL reset_prerun: busy=%b start=%b expected 1 0", busy, start);
        else n_pass++;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({start, eoc, busy, done, err} !== 5'b0 || in_ready !== 1'b1 || run_cycles !== 32'd0 ||
            mem_ctrl_in !== '0 || mem_data_input !== '0)
            $display("FAIL reset_run: start/eoc/busy/done/err=%b in_ready=%b run=%0d expected 00000 1 0",
                     {start, eoc, busy, done, err}, in_ready, run_cycles);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (eoc || start || busy) seen++;
            end
            n_checks++;
            if (seen != 0) $display("FAIL reset_no_eoc: active cycles=%0d expected 0", seen);
            else n_pass++;
        end
    endtask

`ifdef ACCEL_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        drive(1'b1, 2'b01, rnd_data(), 1'b1);
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        repeat (49) @(negedge clk);
        n_checks++;
        if (run_cycles !== 32'd49 || eoc !== 1'b0 || err !== 1'b0)
            $display("FAIL to_before: run=%0d eoc=%b err=%b expected 49 0 0", run_cycles, eoc, err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (eoc !== 1'b1 || done !== 1'b1 || err !== 1'b1 || run_cycles !== 32'd50)
            $display("FAIL to_eoc: eoc=%b done=%b err=%b run=%0d expected 1 1 1 50", eoc, done, err, run_cycles);
        else n_pass++;
        @(negedge clk);
        drive(1'b1, 2'b01, rnd_data(), 1'b1);
        void'(sb.pop_front());
        @(negedge clk);
        n_checks++;
        if (start !== 1'b1 || err !== 1'b1)
            $display("FAIL to_hold: start=%b err=%b expected 1 1", start, err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) $display("FAIL to_clear: err=%b expected 0", err);
        else n_pass++;
        eol = 1'b1;
        @(negedge clk);
        eol = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_ns = 2'b00; in_data = '0; in_last = 1'b0; eol = 1'b0;
        m_sel = 0; m_prev_ns = 2'b00;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_load_run();
        test_toggle();
        test_ns_zero();
        test_reset_mid();
`ifdef ACCEL_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
